// File: rtl/silent_pkg.sv
// Shared types and defaults for the silencer step scheduler.
package silent_pkg;
    localparam int DEF_WIDTH = 13;
    localparam int DEF_DEPTH = 249;
    localparam int ADDR_W    = 8;
    localparam int STEP_W    = 16;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        SWEEP = 2'd2
    } state_t;
endpackage

// File: rtl/silent_step_calc.sv
// Registered one-cycle step unit: moves current duty and phase toward target by at most step.
import silent_pkg::*;

module silent_step_calc #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [WIDTH-1:0]  cur_duty,
    input  logic [WIDTH-1:0]  cur_phase,
    input  logic [WIDTH-1:0]  tgt_duty,
    input  logic [WIDTH-1:0]  tgt_phase,
    input  logic [WIDTH-1:0]  cyc,
    input  logic [STEP_W-1:0] step,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic [WIDTH-1:0]  duty,
    output logic [WIDTH-1:0]  phase
);
    // Wide enough for WIDTH+1 differences and the full 16-bit step.
    localparam int CW = (WIDTH + 1 > STEP_W + 1) ? WIDTH + 1 : STEP_W + 1;

    logic [CW-1:0]    stp_x, d_cur, d_tgt, d_mag;
    logic [CW-1:0]    p_cyc, p_c, p_tgt, diff, back, mv, sum;
    logic             d_up;
    logic [WIDTH-1:0] duty_n, phase_n;

    always_comb begin
        stp_x  = CW'(step);
        d_cur  = CW'(cur_duty);
        d_tgt  = CW'(tgt_duty);
        d_up   = (d_tgt >= d_cur);
        d_mag  = d_up ? (d_tgt - d_cur) : (d_cur - d_tgt);
        duty_n = tgt_duty;
        if (d_mag > stp_x) begin
            duty_n = d_up ? WIDTH'(d_cur + stp_x) : WIDTH'(d_cur - stp_x);
        end

        // A shrunken cycle leaves cur out of range; fold it back once first.
        p_cyc = CW'(cyc);
        p_c   = (CW'(cur_phase) >= p_cyc) ? CW'(cur_phase) - p_cyc : CW'(cur_phase);
        p_tgt = CW'(tgt_phase);
        diff  = (p_tgt >= p_c) ? (p_tgt - p_c) : (p_tgt + p_cyc - p_c);
        back  = p_cyc - diff;
        if (diff <= (p_cyc >> 1)) begin
            mv  = (diff < stp_x) ? diff : stp_x;
            sum = p_c + mv;
            if (sum >= p_cyc) begin
                sum = sum - p_cyc;
            end
        end else begin
            mv  = (back < stp_x) ? back : stp_x;
            sum = (p_c >= mv) ? (p_c - mv) : (p_c + p_cyc - mv);
        end
        phase_n = WIDTH'(sum);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_addr  <= '0;
            duty      <= '0;
            phase     <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_addr <= in_addr;
                duty     <= duty_n;
                phase    <= phase_n;
            end
        end
    end
endmodule

// File: rtl/silent_step_scheduler.sv
// Sweeps all transducers once per update strobe, stepping stored duty/phase toward target.
import silent_pkg::*;

module silent_step_scheduler #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              update,
    input  logic [STEP_W-1:0] step,
    output logic [ADDR_W-1:0] tgt_addr,
    input  logic [WIDTH-1:0]  tgt_duty,
    input  logic [WIDTH-1:0]  tgt_phase,
    input  logic [WIDTH-1:0]  tgt_cycle,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic [WIDTH-1:0]  duty,
    output logic [WIDTH-1:0]  phase,
    output logic              busy,
    output logic              overrun,
    output logic [1:0]        fsm_state
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    // Output stream: out_valid qualifies out_addr/duty/phase for one cycle, no back-pressure.
    state_t              state;
    logic [ADDR_W-1:0]   clr_addr, s1_addr;
    logic                issue, s1_valid;
    logic [2*WIDTH-1:0]  ram [DEPTH];
    logic [2*WIDTH-1:0]  cur_q, ram_wdata;
    logic [ADDR_W-1:0]   ram_waddr;
    logic                ram_we;

    assign fsm_state = state;

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdata = '0;
        if (state == CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_addr;
        end else if (out_valid) begin
            ram_we    = 1'b1;
            ram_waddr = out_addr;
            ram_wdata = {duty, phase};
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_waddr] <= ram_wdata;
        end
        cur_q <= ram[tgt_addr];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= CLEAR;
            clr_addr <= '0;
            tgt_addr <= '0;
            issue    <= 1'b0;
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            busy     <= 1'b1;
            overrun  <= 1'b0;
        end else begin
            s1_valid <= issue;
            s1_addr  <= tgt_addr;
            case (state)
                CLEAR: begin
                    if (clr_addr == LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                IDLE: begin
                    if (update) begin
                        state    <= SWEEP;
                        busy     <= 1'b1;
                        tgt_addr <= '0;
                        issue    <= 1'b1;
                    end
                end
                SWEEP: begin
                    if (update) begin
                        overrun <= 1'b1;
                    end
                    if (issue) begin
                        if (tgt_addr == LAST) begin
                            issue    <= 1'b0;
                            tgt_addr <= '0;
                        end else begin
                            tgt_addr <= tgt_addr + 1'b1;
                        end
                    end
                    // The sweep ends when the last transducer's result leaves the step unit.
                    if (out_valid && out_addr == LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    silent_step_calc #(.WIDTH(WIDTH)) u_calc (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s1_valid),
        .in_addr   (s1_addr),
        .cur_duty  (cur_q[2*WIDTH-1:WIDTH]),
        .cur_phase (cur_q[WIDTH-1:0]),
        .tgt_duty  (tgt_duty),
        .tgt_phase (tgt_phase),
        .cyc       (tgt_cycle),
        .step      (step),
        .out_valid (out_valid),
        .out_addr  (out_addr),
        .duty      (duty),
        .phase     (phase)
    );
endmodule

// File: tb/tb_silent_step_scheduler.sv
// Scoreboard bench for silent_step_scheduler against a behavioural per-transducer model.
module tb_silent_step_scheduler;
    localparam int W  = 13;
    localparam int D  = 249;
    localparam int AW = 8;
    localparam int EW = AW + 2 * W;

    logic          clk;
    logic          rst_n;
    logic          update;
    logic [15:0]   step;
    logic [AW-1:0] tgt_addr;
    logic [W-1:0]  tgt_duty, tgt_phase, tgt_cycle;
    logic          out_valid;
    logic [AW-1:0] out_addr;
    logic [W-1:0]  duty, phase;
    logic          busy, overrun;
    logic [1:0]    fsm_state;

    silent_step_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .update    (update),
        .step      (step),
        .tgt_addr  (tgt_addr),
        .tgt_duty  (tgt_duty),
        .tgt_phase (tgt_phase),
        .tgt_cycle (tgt_cycle),
        .out_valid (out_valid),
        .out_addr  (out_addr),
        .duty      (duty),
        .phase     (phase),
        .busy      (busy),
        .overrun   (overrun),
        .fsm_state (fsm_state)
    );

    // Clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    // Target buffer with one-cycle read latency, and reference model state
    logic [W-1:0] mem_duty [D];
    logic [W-1:0] mem_phase[D];
    logic [W-1:0] mem_cyc  [D];
    int           m_duty   [D];
    int           m_phase  [D];
    int           last_addr = 0;

    always @(negedge clk) begin
        tgt_duty  = mem_duty[last_addr];
        tgt_phase = mem_phase[last_addr];
        tgt_cycle = mem_cyc[last_addr];
        last_addr = int'(tgt_addr);
        if (last_addr >= D) last_addr = 0;
    end

    // Scoreboard
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_exp;
    int n_cmp = 0;
    int n_bad = 0;
    int n_out = 0;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            n_out++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_output: got addr %0d duty %0d phase %0d, required no output",
                         out_addr, duty, phase);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({out_addr, duty, phase} !== mon_exp) begin
                    n_bad++;
                    $display("FAIL sweep_output: got addr %0d duty %0d phase %0d, required addr %0d duty %0d phase %0d",
                             out_addr, duty, phase, mon_exp[EW-1 -: AW], mon_exp[2*W-1 -: W], mon_exp[W-1:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    function automatic int mdl_duty(input int cur, input int tgt, input int stp);
        int d;
        d = tgt - cur;
        if ((d < 0 ? -d : d) <= stp) return tgt;
        return (d > 0) ? cur + stp : cur - stp;
    endfunction

    function automatic int mdl_phase(input int cur, input int tgt, input int cyc, input int stp);
        int c, diff, mv;
        c    = (cur >= cyc) ? cur - cyc : cur;
        diff = ((tgt - c) % cyc + cyc) % cyc;
        if (diff <= cyc / 2) begin
            mv = (diff < stp) ? diff : stp;
            return (c + mv) % cyc;
        end
        mv = ((cyc - diff) < stp) ? (cyc - diff) : stp;
        return ((c - mv) % cyc + cyc) % cyc;
    endfunction

    task automatic model_sweep(input int stp);
        for (int a = 0; a < D; a++) begin
            m_duty[a]  = mdl_duty(m_duty[a], int'(mem_duty[a]), stp);
            m_phase[a] = mdl_phase(m_phase[a], int'(mem_phase[a]), int'(mem_cyc[a]), stp);
            exp_q.push_back({AW'(a), W'(m_duty[a]), W'(m_phase[a])});
        end
    endtask

    // Driver tasks
    task automatic fill(input int d, input int p, input int c);
        for (int a = 0; a < D; a++) begin
            mem_duty[a]  = d[W-1:0];
            mem_phase[a] = p[W-1:0];
            mem_cyc[a]   = c[W-1:0];
        end
    endtask

    task automatic fill_random();
        int c;
        for (int a = 0; a < D; a++) begin
            c            = $urandom_range(4097, 8191);
            mem_cyc[a]   = c[W-1:0];
            mem_phase[a] = W'($urandom_range(0, c - 1));
            mem_duty[a]  = W'($urandom_range(0, 8191));
        end
    endtask

    function automatic logic [15:0] pick_step();
        case ($urandom_range(0, 3))
            0:       return 16'd0;
            1:       return 16'($urandom_range(1, 64));
            2:       return 16'($urandom_range(65, 5000));
            default: return 16'hFFFF;
        endcase
    endfunction

    task automatic run_sweep(input logic [15:0] stp, input int pulse_at, input string tag);
        int cnt;
        int base;
        @(negedge clk);
        step = stp;
        model_sweep(int'(stp));
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        base = n_out;
        cnt  = 0;
        while (busy === 1'b1 && cnt < 2000) begin
            cnt++;
            update = (cnt == pulse_at);
            @(negedge clk);
        end
        update = 1'b0;
        check({tag, "_busy_span"}, cnt, D + 2);
        check({tag, "_out_count"}, n_out - base, D);
    endtask

    task automatic reset_and_clear(input string tag);
        int cnt;
        rst_n  = 1'b0;
        update = 1'b0;
        repeat (3) @(negedge clk);
        check({tag, "_rst_tgt_addr"}, tgt_addr, 0);
        check({tag, "_rst_out_valid"}, out_valid, 0);
        check({tag, "_rst_out_addr"}, out_addr, 0);
        check({tag, "_rst_duty"}, duty, 0);
        check({tag, "_rst_phase"}, phase, 0);
        check({tag, "_rst_overrun"}, overrun, 0);
        check({tag, "_rst_busy"}, busy, 1);
        exp_q.delete();
        for (int a = 0; a < D; a++) begin
            m_duty[a]  = 0;
            m_phase[a] = 0;
        end
        rst_n = 1'b1;
        cnt   = 0;
        // An update strobe during clearing must be ignored entirely.
        while (busy === 1'b1 && cnt < 2000) begin
            cnt++;
            update = (cnt == 50);
            @(negedge clk);
        end
        update = 1'b0;
        check({tag, "_clear_busy_span"}, cnt, D);
        check({tag, "_clear_overrun"}, overrun, 0);
        check({tag, "_clear_to_idle"}, fsm_state, 1);
    endtask

    // Main sequence
    initial begin
        int cnt;
        rst_n  = 1'b0;
        update = 1'b0;
        step   = 16'd0;
        fill(0, 0, 4096);
        reset_and_clear("por");

        run_sweep(16'd7, -1, "t1_zero");

        fill(100, 0, 4096);
        repeat (11) run_sweep(16'd10, -1, "t2_duty");

        fill(100, 4090, 4096);
        run_sweep(16'hFFFF, -1, "t3_jump");
        fill(100, 5, 4096);
        repeat (4) run_sweep(16'd4, -1, "t3_wrap");

        fill(100, 10, 4096);
        run_sweep(16'hFFFF, -1, "t4_jump");
        fill(100, 4000, 4096);
        repeat (3) run_sweep(16'd50, -1, "t4_back");

        fill(100, 0, 4096);
        run_sweep(16'hFFFF, -1, "tie_jump");
        fill(100, 2048, 4096);
        run_sweep(16'd100, -1, "tie_fwd");
        fill(3000, 1000, 4096);
        run_sweep(16'd0, -1, "step_zero");

        repeat (6) begin
            fill_random();
            run_sweep(pick_step(), -1, "rand");
        end

        check("t5_overrun_before", overrun, 0);
        fill_random();
        run_sweep(pick_step(), 100, "t5_overrun");
        check("t5_overrun_set", overrun, 1);
        repeat (20) @(negedge clk);
        check("t5_overrun_sticky", overrun, 1);

        fill(500, 300, 4096);
        @(negedge clk);
        step = 16'hFFFF;
        model_sweep(65535);
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        cnt = 0;
        while (tgt_addr !== 8'd120 && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
        check("t6_reach_addr120", tgt_addr, 120);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_abort_out_valid", out_valid, 0);
        reset_and_clear("t6");

        fill(100, 0, 4096);
        run_sweep(16'd10, -1, "t6_after_clear");

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
